// File: rtl/sawtooth_rate_detector.sv
// Recovers period, per-sample increment and lock status of a PCM sawtooth stream.
// Optional Hz readout through a restoring divider, built when SAWTOOTH_RATE_CALC_EN is defined.
module sawtooth_rate_detector #(
   parameter int BIT_WIDTH    = 16,
   parameter int SAMPLE_RATE  = 48000,
   parameter int PERIOD_WIDTH = 16,
   parameter int LOCK_COUNT   = 4,
   parameter int TOLERANCE    = 1
) (
   input  logic                        clk_audio,
   input  logic                        reset,
   input  logic                        sample_en,
   input  logic signed [BIT_WIDTH-1:0] level,
   output logic [PERIOD_WIDTH-1:0]     period,
   output logic [BIT_WIDTH-1:0]        increment,
   output logic                        wrap_pulse,
   output logic                        locked,
   output logic [10:0]                 rate_hz,
   output logic                        rate_valid
);
   typedef enum logic [1:0] {IDLE, SEEK, MEASURE, LOCKED} state_t;

   localparam logic [PERIOD_WIDTH-1:0] CNT_ONE  = PERIOD_WIDTH'(1);
   // One below all-ones: the counter is never allowed to reach all-ones or wrap.
   localparam logic [PERIOD_WIDTH-1:0] CNT_LAST = {{(PERIOD_WIDTH-1){1'b1}}, 1'b0};
   localparam logic [PERIOD_WIDTH-1:0] TOL      = PERIOD_WIDTH'(TOLERANCE);
   localparam logic [3:0]              LOCK_N   = 4'(LOCK_COUNT);

   state_t                    state_reg, state_next;
   logic [BIT_WIDTH-1:0]      prev_level_reg;
   logic [PERIOD_WIDTH-1:0]   counter_reg, counter_next;
   logic [PERIOD_WIDTH-1:0]   period_reg, period_next;
   logic [BIT_WIDTH-1:0]      increment_reg, increment_next;
   logic                      wrap_pulse_reg, wrap_pulse_next;
   logic [3:0]                match_reg, match_next;
   logic signed [BIT_WIDTH:0] delta;
   logic [PERIOD_WIDTH-1:0]   period_diff;
   logic                      is_wrap, is_rise, is_match;
   logic                      div_start;

   assign delta       = $signed({level[BIT_WIDTH-1], level})
                      - $signed({prev_level_reg[BIT_WIDTH-1], prev_level_reg});
   assign is_wrap     = delta[BIT_WIDTH];
   assign is_rise     = !delta[BIT_WIDTH] && (delta != '0);
   assign period_diff = (counter_reg >= period_reg) ? (counter_reg - period_reg)
                                                    : (period_reg - counter_reg);
   assign is_match    = (period_diff <= TOL);

   always_ff @(posedge clk_audio) begin
      if (reset) begin
         state_reg      <= IDLE;
         prev_level_reg <= '0;
         counter_reg    <= '0;
         period_reg     <= '0;
         increment_reg  <= '0;
         wrap_pulse_reg <= 1'b0;
         match_reg      <= '0;
      end else begin
         state_reg      <= state_next;
         counter_reg    <= counter_next;
         period_reg     <= period_next;
         increment_reg  <= increment_next;
         wrap_pulse_reg <= wrap_pulse_next;
         match_reg      <= match_next;
         if (sample_en) begin
            prev_level_reg <= level;
         end
      end
   end

   always_comb begin
      state_next      = state_reg;
      counter_next    = counter_reg;
      period_next     = period_reg;
      increment_next  = increment_reg;
      match_next      = match_reg;
      wrap_pulse_next = 1'b0;
      div_start       = 1'b0;
      if (sample_en) begin
         if (is_rise && (state_reg != IDLE)) begin
            increment_next = delta[BIT_WIDTH-1:0];
         end
         case (state_reg)
            IDLE: state_next = SEEK;
            SEEK: begin
               if (is_wrap) begin
                  counter_next = CNT_ONE;
                  state_next   = MEASURE;
               end
            end
            default: begin
               if (is_wrap) begin
                  period_next     = counter_reg;
                  counter_next    = CNT_ONE;
                  wrap_pulse_next = 1'b1;
                  if (is_match) begin
                     match_next = (match_reg >= LOCK_N) ? LOCK_N : (match_reg + 4'd1);
                  end else begin
                     match_next = '0;
                  end
                  state_next = (match_next >= LOCK_N) ? LOCKED : MEASURE;
                  div_start  = (state_next == LOCKED) && (counter_reg != '0);
               end else if (counter_reg == CNT_LAST) begin
                  // Flat or stalled input: drop lock and look for a fresh wrap.
                  counter_next = '0;
                  match_next   = '0;
                  state_next   = SEEK;
               end else begin
                  counter_next = counter_reg + CNT_ONE;
               end
            end
         endcase
      end
   end

   assign period     = period_reg;
   assign increment  = increment_reg;
   assign wrap_pulse = wrap_pulse_reg;
   assign locked     = (state_reg == LOCKED);

`ifdef SAWTOOTH_RATE_CALC_EN
   // Quotient is 11 bits wide: saturation is decided up front, so only 11 iterations are needed.
   localparam int QW = 11;
   localparam logic [PERIOD_WIDTH+QW:0] SR_WIDE = (PERIOD_WIDTH+QW+1)'(SAMPLE_RATE);
   localparam logic [QW-1:0]            SR_LOW  = SR_WIDE[QW-1:0];
   localparam logic [PERIOD_WIDTH-1:0]  SR_HIGH = PERIOD_WIDTH'(SR_WIDE >> QW);

   logic                    div_busy_reg, div_sat_reg, rate_valid_reg;
   logic [3:0]              div_step_reg;
   logic [PERIOD_WIDTH-1:0] div_rem_reg, div_divisor_reg;
   logic [QW-1:0]           div_dividend_reg, div_quot_reg, rate_hz_reg;
   logic [PERIOD_WIDTH:0]   div_trial;
   logic                    div_fits, div_sat;

   assign div_trial = {div_rem_reg, div_dividend_reg[QW-1]};
   assign div_fits  = (div_trial >= {1'b0, div_divisor_reg});
   assign div_sat   = (SR_WIDE >= {1'b0, counter_reg, {QW{1'b0}}});

   always_ff @(posedge clk_audio) begin
      if (reset) begin
         div_busy_reg     <= 1'b0;
         div_sat_reg      <= 1'b0;
         div_step_reg     <= '0;
         div_rem_reg      <= '0;
         div_divisor_reg  <= '0;
         div_dividend_reg <= '0;
         div_quot_reg     <= '0;
         rate_hz_reg      <= '0;
         rate_valid_reg   <= 1'b0;
      end else if (div_start) begin
         div_busy_reg     <= 1'b1;
         div_sat_reg      <= div_sat;
         div_step_reg     <= '0;
         div_rem_reg      <= SR_HIGH;
         div_dividend_reg <= SR_LOW;
         div_divisor_reg  <= counter_reg;
         rate_valid_reg   <= 1'b0;
      end else if (state_next != LOCKED) begin
         // Losing lock abandons any division in flight.
         div_busy_reg   <= 1'b0;
         rate_valid_reg <= 1'b0;
      end else if (div_busy_reg) begin
         div_rem_reg      <= div_fits ? (div_trial[PERIOD_WIDTH-1:0] - div_divisor_reg)
                                      : div_trial[PERIOD_WIDTH-1:0];
         div_quot_reg     <= {div_quot_reg[QW-2:0], div_fits};
         div_dividend_reg <= div_dividend_reg << 1;
         div_step_reg     <= div_step_reg + 4'd1;
         if (div_step_reg == 4'(QW-1)) begin
            div_busy_reg   <= 1'b0;
            rate_valid_reg <= 1'b1;
            rate_hz_reg    <= div_sat_reg ? {QW{1'b1}} : {div_quot_reg[QW-2:0], div_fits};
         end
      end
   end

   assign rate_hz    = rate_hz_reg;
   assign rate_valid = rate_valid_reg;
`else
   localparam logic [31:0] SR_UNUSED = SAMPLE_RATE;
   logic unused_cfg;
   assign unused_cfg = ^{1'b0, SR_UNUSED, div_start};
   assign rate_hz    = '0;
   assign rate_valid = 1'b0;
`endif
endmodule

// File: tb/tb_sawtooth_rate_detector.sv
// Randomized bench for sawtooth_rate_detector with a sample-level reference model.
module tb_sawtooth_rate_detector;
   localparam int BW  = 16;
   localparam int SR  = 48000;
   localparam int PW  = 10;
   localparam int LC  = 4;
   localparam int TOL = 1;

   logic                 clk_audio = 1'b0;
   logic                 reset = 1'b1;
   logic                 sample_en = 1'b0;
   logic signed [BW-1:0] level = '0;
   logic [PW-1:0]        period;
   logic [BW-1:0]        increment;
   logic                 wrap_pulse;
   logic                 locked;
   logic [10:0]          rate_hz;
   logic                 rate_valid;

   int checks = 0;
   int errors = 0;
   int acc = 0;

   always #5 clk_audio = ~clk_audio;

   sawtooth_rate_detector #(
      .BIT_WIDTH(BW), .SAMPLE_RATE(SR), .PERIOD_WIDTH(PW),
      .LOCK_COUNT(LC), .TOLERANCE(TOL)
   ) dut (
      .clk_audio(clk_audio), .reset(reset), .sample_en(sample_en), .level(level),
      .period(period), .increment(increment), .wrap_pulse(wrap_pulse),
      .locked(locked), .rate_hz(rate_hz), .rate_valid(rate_valid)
   );

   task automatic chk(string name, int act, int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: tracks the waveform sample by sample with plain integers.
   bit m_seen, m_meas, m_locked, m_wrap;
   int m_prev, m_count, m_period, m_incr, m_match, m_d, m_diff;
   bit compare_en = 1'b0;

   always @(posedge clk_audio) begin
      m_wrap = 1'b0;
      if (reset) begin
         m_seen = 0; m_meas = 0; m_locked = 0; m_prev = 0;
         m_count = 0; m_period = 0; m_incr = 0; m_match = 0;
         compare_en = 1'b1;
      end else if (sample_en) begin
         m_d = int'(level) - m_prev;
         if (m_seen) begin
            if (m_d > 0) m_incr = m_d & 32'hFFFF;
            if (!m_meas) begin
               if (m_d < 0) begin
                  m_meas = 1; m_count = 1;
               end
            end else if (m_d < 0) begin
               m_wrap = 1'b1;
               m_diff = (m_count > m_period) ? m_count - m_period : m_period - m_count;
               if (m_diff <= TOL) m_match = (m_match < LC) ? m_match + 1 : LC;
               else m_match = 0;
               m_period = m_count;
               m_count  = 1;
               m_locked = (m_match == LC);
            end else if (m_count + 1 == (1 << PW) - 1) begin
               m_meas = 0; m_count = 0; m_match = 0; m_locked = 0;
            end else begin
               m_count++;
            end
         end
         m_seen = 1;
         m_prev = int'(level);
      end
   end

   always @(negedge clk_audio) begin
      if (compare_en) begin
         chk("period", int'(period), m_period);
         chk("increment", int'(increment), m_incr);
         chk("wrap_pulse", int'(wrap_pulse), int'(m_wrap));
         chk("locked", int'(locked), int'(m_locked));
`ifdef SAWTOOTH_RATE_CALC_EN
         if (rate_valid) begin
            chk("rate_valid_implies_locked", int'(locked), 1);
            if (m_period != 0)
               chk("rate_hz", int'(rate_hz), (SR / m_period > 2047) ? 2047 : SR / m_period);
         end
`else
         chk("rate_hz_off", int'(rate_hz), 0);
         chk("rate_valid_off", int'(rate_valid), 0);
`endif
         if (wrap_pulse)
            $display("wrap t=%0t period=%0d increment=%0d locked=%0d", $time, period, increment, locked);
      end
   end

   task automatic drive(bit en, int lvl);
      @(negedge clk_audio);
      sample_en = en;
      level     = BW'(lvl);
   endtask

   task automatic ramp(int step, int n, int mode);
      bit en;
      for (int i = 0; i < n; i++) begin
         case (mode)
            0:       en = 1'b1;
            1:       en = (i % 2 == 0);
            default: en = 1'($urandom_range(0, 1));
         endcase
         if (en) acc += step;
         drive(en, acc);
      end
   endtask

   task automatic pulse_reset(string tag);
      reset = 1'b1;
      @(negedge clk_audio);
      chk({tag, "_period0"}, int'(period), 0);
      chk({tag, "_increment0"}, int'(increment), 0);
      chk({tag, "_wrap0"}, int'(wrap_pulse), 0);
      chk({tag, "_locked0"}, int'(locked), 0);
      chk({tag, "_rate0"}, int'(rate_hz), 0);
      chk({tag, "_rate_valid0"}, int'(rate_valid), 0);
      reset = 1'b0;
   endtask

   initial begin
      int p_hold;
      bit found;
      @(negedge clk_audio);
      pulse_reset("reset");
      acc = int'($urandom_range(0, 65535));

      // 1 kHz ramp, continuous samples
      ramp(1365, 500, 0);
      drive(0, acc);
      chk("t1_period_48_49", int'(period == 48 || period == 49), 1);
      chk("t1_increment", int'(increment), 1365);
      chk("t1_locked", int'(locked), 1);

      // Same ramp, sample_en every other cycle
      pulse_reset("t2_reset");
      ramp(1365, 1000, 1);
      drive(0, acc);
      chk("t2_period_48_49", int'(period == 48 || period == 49), 1);
      chk("t2_increment", int'(increment), 1365);
      chk("t2_locked", int'(locked), 1);

      // Rate doubles: lock drops, then relocks around 24
      ramp(2730, 400, 0);
      drive(0, acc);
      chk("t3_period_23_25", int'(period >= 23 && period <= 25), 1);
      chk("t3_increment", int'(increment), 2730);
      chk("t3_locked", int'(locked), 1);

      // Flat input: counter saturates, lock drops, period holds
      for (int i = 0; i < 3; i++) drive(1, 0);
      drive(0, 0);
      p_hold = int'(period);
      for (int i = 0; i < 1100; i++) drive(1, 0);
      drive(0, 0);
      acc = 0;
      chk("t4_locked", int'(locked), 0);
      chk("t4_period_hold", int'(period), p_hold);

      // Mid-period reset, then reset right after a locked wrap
      ramp(1365, 400, 0);
      ramp(1365, 20, 0);
      pulse_reset("t5_midperiod");
      ramp(1365, 400, 0);
      found = 1'b0;
      for (int i = 0; i < 100 && !found; i++) begin
         acc += 1365;
         drive(1, acc);
         if (wrap_pulse) found = 1'b1;
      end
      chk("t5_wrap_seen", int'(found), 1);
      pulse_reset("t5_middiv");
      ramp(1365, 500, 0);
      drive(0, acc);
      chk("t5_relocked", int'(locked), 1);

      // +1 per sample: period far beyond the counter, never locks
      ramp(1, 2500, 0);
      drive(0, acc);
      chk("t6_locked", int'(locked), 0);

      // Random rates and sample_en density
      for (int s = 0; s < 6; s++) begin
         acc = int'($urandom_range(0, 65535));
         ramp(int'($urandom_range(300, 6000)), 300, 2);
      end
      drive(0, acc);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
